hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush, multi-cycle MDU hold.
// Latency: forwarding/stall/flush are combinational; the MDU FSM advances one state per clk.
// Backpressure: holds PC, IF/ID and ID/EX while the MDU is busy; stalls are released on mdu_done or timeout.
module hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic       regWrite_E,
    input  logic [1:0] resultSrc_E,
    input  logic [4:0] rd_M,
    input  logic       regWrite_M,
    input  logic [4:0] rd_W,
    input  logic       regWrite_W,
    input  logic       pcSrc_E,
    input  logic       mdu_op_E,
    input  logic       mdu_done,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       flush_D,
    output logic       flush_E,
    output logic       flush_M,
    output logic [1:0] forwardA_E,
    output logic [1:0] forwardB_E,
    output logic       mdu_start,
    output logic       mdu_busy,
    output logic       mdu_timeout
);

    // Counter wide enough to hold MDU_TIMEOUT-1; at least one bit for tiny timeouts.
    localparam int CW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MDU_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            lw_stall;
    logic [1:0]      fwd_a, fwd_b;

    // Forward select for one EX operand: MEM result wins over WB result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic       wr_m, input logic [4:0] rd_m,
                                           input logic       wr_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        lw_stall = (resultSrc_E == 2'b01) && (rd_E != 5'd0) &&
                   ((rd_E == rs1_D) || (rd_E == rs2_D));
        fwd_a    = fwd_sel(rs1_E, regWrite_M, rd_M, regWrite_W, rd_W);
        fwd_b    = fwd_sel(rs2_E, regWrite_M, rd_M, regWrite_W, rd_W);
    end

    // Next-state logic and hazard outputs; reset blanks every output immediately.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall_F     = 1'b0;
        stall_D     = 1'b0;
        stall_E     = 1'b0;
        flush_D     = 1'b0;
        flush_E     = 1'b0;
        flush_M     = 1'b0;
        mdu_start   = 1'b0;
        mdu_busy    = 1'b0;
        mdu_timeout = 1'b0;
        forwardA_E  = fwd_a;
        forwardB_E  = fwd_b;

        case (state_q)
            IDLE: begin
                // mdu_done is deliberately not looked at here.
                if (mdu_op_E) begin
                    mdu_start = 1'b1;
                    stall_F   = 1'b1;
                    stall_D   = 1'b1;
                    stall_E   = 1'b1;
                    flush_M   = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = '0;
                end else begin
                    stall_F = lw_stall;
                    stall_D = lw_stall;
                    flush_D = pcSrc_E;
                    flush_E = lw_stall | pcSrc_E;
                end
            end
            BUSY: begin
                if (mdu_done || (cnt_q == CNT_LAST)) begin
                    // Release cycle: MDU result moves to MEM on the next edge.
                    stall_F     = lw_stall;
                    stall_D     = lw_stall;
                    flush_D     = pcSrc_E;
                    flush_E     = lw_stall | pcSrc_E;
                    mdu_timeout = ~mdu_done;
                    state_d     = IDLE;
                end else begin
                    stall_F  = 1'b1;
                    stall_D  = 1'b1;
                    stall_E  = 1'b1;
                    flush_M  = 1'b1;
                    mdu_busy = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (reset) begin
            stall_F     = 1'b0;
            stall_D     = 1'b0;
            stall_E     = 1'b0;
            flush_D     = 1'b0;
            flush_E     = 1'b0;
            flush_M     = 1'b0;
            mdu_start   = 1'b0;
            mdu_busy    = 1'b0;
            mdu_timeout = 1'b0;
            forwardA_E  = 2'b00;
            forwardB_E  = 2'b00;
        end
    end

    // MDU FSM state and cycle counter; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with MDU_TIMEOUT=8.
// Inputs change 1 time unit after posedge; outputs are sampled 3 units later.
// Fixed cycle counts only, so the run always terminates.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       regWrite_E, regWrite_M, regWrite_W;
    logic [1:0] resultSrc_E;
    logic       pcSrc_E, mdu_op_E, mdu_done;
    logic       stall_F, stall_D, stall_E, flush_D, flush_E, flush_M;
    logic [1:0] forwardA_E, forwardB_E;
    logic       mdu_start, mdu_busy, mdu_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_ctrl #(.MDU_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .regWrite_E(regWrite_E), .resultSrc_E(resultSrc_E),
        .rd_M(rd_M), .regWrite_M(regWrite_M), .rd_W(rd_W), .regWrite_W(regWrite_W),
        .pcSrc_E(pcSrc_E), .mdu_op_E(mdu_op_E), .mdu_done(mdu_done),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M),
        .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
        .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_timeout(mdu_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {stall_F,stall_D,stall_E,flush_D,flush_E,flush_M,fwdA,fwdB,start,busy,timeout}
    function automatic logic [31:0] outs();
        return {19'd0, stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
                forwardA_E, forwardB_E, mdu_start, mdu_busy, mdu_timeout};
    endfunction

    // {stall_F, stall_D, stall_E, flush_D, flush_E, flush_M}
    function automatic logic [31:0] ctl();
        return {26'd0, stall_F, stall_D, stall_E, flush_D, flush_E, flush_M};
    endfunction

    task automatic clear_inputs();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        regWrite_E = 0; regWrite_M = 0; regWrite_W = 0; resultSrc_E = 2'b00;
        pcSrc_E = 0; mdu_op_E = 0; mdu_done = 0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int n_start, n_stallE, n_busy, n_to;

    initial begin
        clear_inputs();
        // Inputs that would forward, to prove reset blanks the forward selects.
        regWrite_M = 1; rd_M = 5; rs1_E = 5; rs2_E = 5;
        reset = 1;
        #3;
        chk("reset_outs", outs(), 32'd0);
        next_cycle();
        chk("reset_outs_clk", outs(), 32'd0);
        reset = 0;
        clear_inputs();
        #3;
        chk("idle_after_reset", outs(), 32'd0);

        // Forwarding: MEM beats WB, WB used when rd_M is x0.
        next_cycle();
        regWrite_M = 1; rd_M = 5; regWrite_W = 1; rd_W = 5; rs1_E = 5; rs2_E = 9;
        #3 chk("fwdA_mem", forwardA_E, 2'b10);
        chk("fwdB_none", forwardB_E, 2'b00);
        rd_M = 0;
        #1 chk("fwdA_wb", forwardA_E, 2'b01);
        rs2_E = 5; regWrite_W = 0;
        #1 chk("fwdA_nowr", forwardA_E, 2'b00);
        regWrite_M = 1; rd_M = 9; rs2_E = 9;
        #1 chk("fwdB_mem", forwardB_E, 2'b10);
        clear_inputs();

        // Load-use stall lasts one cycle; next cycle EX holds the inserted bubble.
        next_cycle();
        resultSrc_E = 2'b01; rd_E = 3; rs2_D = 3; rs1_D = 7; regWrite_E = 1;
        #3 chk("lw_stall", ctl(), 32'b110010);
        next_cycle();
        resultSrc_E = 2'b00; rd_E = 0; regWrite_E = 0;
        #3 chk("lw_stall_gone", ctl(), 32'b000000);
        resultSrc_E = 2'b01; rd_E = 0; rs2_D = 0;
        #1 chk("lw_rd0_nostall", ctl(), 32'b000000);

        // Branch plus load-use together.
        next_cycle();
        resultSrc_E = 2'b01; rd_E = 4; rs1_D = 4; pcSrc_E = 1;
        #3 chk("br_and_lw", ctl(), 32'b110110);
        resultSrc_E = 2'b00;
        #1 chk("br_only", ctl(), 32'b000110);
        clear_inputs();

        // MDU op, done arrives after four BUSY cycles (cycle 5 after start).
        n_start = 0; n_stallE = 0; n_busy = 0;
        for (int i = 0; i <= 5; i++) begin
            next_cycle();
            mdu_op_E = 1;
            mdu_done = (i == 0) || (i == 5);   // done in the start cycle must be ignored
            pcSrc_E  = (i == 2);
            #3;
            n_start  += int'(mdu_start);
            n_stallE += int'(stall_E);
            n_busy   += int'(mdu_busy);
            if (i == 2) chk("busy_branch_ignored", {flush_D, flush_E}, 2'b00);
            if (i == 5) chk("release_ctl", ctl(), 32'b000000);
        end
        chk("mdu_start_cnt", n_start, 1);
        chk("stall_E_cnt", n_stallE, 5);
        chk("mdu_busy_cnt", n_busy, 4);

        // Back-to-back: op right after release restarts, then never gets done.
        next_cycle();
        mdu_done = 0; pcSrc_E = 0;
        #3 chk("b2b_start", {mdu_start, stall_E, flush_M}, 3'b111);
        n_to = 0;
        for (int j = 1; j <= 8; j++) begin
            next_cycle();
            #3;
            n_to += int'(mdu_timeout);
            if (j == 7) chk("busy_cycle7", {mdu_busy, stall_E, mdu_timeout}, 3'b110);
            if (j == 8) chk("timeout_cycle8", {mdu_busy, stall_E, mdu_timeout}, 3'b001);
        end
        chk("timeout_pulses", n_to, 1);
        next_cycle();
        mdu_op_E = 0;
        #3 chk("idle_after_timeout", outs(), 32'd0);

        // Reset mid-BUSY between edges.
        next_cycle();
        mdu_op_E = 1;
        next_cycle();
        next_cycle();
        #3 chk("busy_before_reset", mdu_busy, 1'b1);
        reset = 1;
        #1 chk("reset_mid_busy", outs(), 32'd0);
        next_cycle();
        mdu_op_E = 0;
        #2 reset = 0;
        #1 chk("after_reset_idle", outs(), 32'd0);
        n_to = 0; n_stallE = 0;
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            #3;
            n_to     += int'(mdu_timeout);
            n_stallE += int'(stall_E);
        end
        chk("no_timeout_after_reset", n_to, 0);
        chk("no_stall_after_reset", n_stallE, 0);
        next_cycle();
        mdu_op_E = 1;
        #3 chk("start_after_reset", mdu_start, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
